// File: rtl/mem_io_ctrl.sv
// Memory and I/O controller: word-addressed RAM, TX FIFO with valid/ready drain,
// RX holding register and a small memory-mapped status window.
module mem_io_ctrl #(
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] datao,
  input  logic        rw,
  output logic [31:0] data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        fifo_overflow
);

  localparam int unsigned AddrW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [31:0] TxAddr   = IO_BASE;
  localparam logic [31:0] StatAddr = IO_BASE + 32'd1;
  localparam logic [31:0] RxAddr   = IO_BASE + 32'd2;

  logic [31:0] mem_q  [MEM_WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            rx_valid_q, rx_valid_d;
  logic [31:0]     rx_data_q, rx_data_d;

  logic is_ram, is_tx, is_stat, is_rx;
  logic wr_en, full, empty, push, pop, ovf_set, ovf_clr, rx_clr, rx_capture;

  assign is_ram  = (address < 32'(MEM_WORDS));
  assign is_tx   = (address == TxAddr);
  assign is_stat = (address == StatAddr);
  assign is_rx   = (address == RxAddr);
  assign wr_en   = ~rw;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  assign out_valid     = ~empty;
  assign out_data      = fifo_q[rd_ptr_q];
  assign in_ready      = ~rx_valid_q;
  assign fifo_overflow = ovf_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop        = out_valid & out_ready;
  assign push       = wr_en & is_tx & (~full | pop);
  assign ovf_set    = wr_en & is_tx & full & ~pop;
  assign ovf_clr    = wr_en & is_stat & datao[3];
  assign rx_clr     = wr_en & is_rx;
  assign rx_capture = in_valid & in_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // Set wins over a same-cycle clear.
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    if (rx_capture) begin
      rx_valid_d = 1'b1;
      rx_data_d  = in_data;
    end else if (rx_clr) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Storage arrays carry no reset; reset still blocks any write in its cycle.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && is_ram) mem_q[address[AddrW-1:0]] <= datao;
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= datao;
  end

  always_comb begin
    data = '0;
    if (is_ram)       data = mem_q[address[AddrW-1:0]];
    else if (is_tx)   data = {{(32 - CntW){1'b0}}, count_q};
    else if (is_stat) data = {28'b0, ovf_q, rx_valid_q, empty, full};
    else if (is_rx)   data = rx_valid_q ? rx_data_q : 32'b0;
  end

endmodule
